snoop_controller: RTL and testbench
===================================

# snoop_controller

Bus-side responder of the snoopy invalidate-protocol cache; the counterpart to the CPU-side controller that issues BUS_READ, BUS_READ_EXCLUSIVE, BUS_INVALIDATE and BUS_WRITEBACK. It watches the command and address the current bus owner drives. It looks the block up through the cache's snoop port. If the protocol requires it, it flushes a dirty block to memory word by word. It then writes the protocol's next state and acknowledges, so the requester's `isInvalidated` (AND of all snoopers' acks) can rise.

## Interface
- OFFSET_WIDTH, 2: log2 words per block.
- INDEX_WIDTH, 4: set index width.
- TAG_WIDTH, 8: tag width.
- DATA_WIDTH, 32: word width.
- STATE_TYPE, logic[1:0]: protocol state type.
- INVALID_STATE, 0: invalid encoding.

Ports (A = TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH):
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- commandIn  in  Command  bus command (commands package).
- addressIn  in  A  bus address {tag, index, offset}.
- ownRequest  in  1  this cache is the bus owner; its own commands are ignored.
- snoopIndex / snoopOffset  out  INDEX_WIDTH / OFFSET_WIDTH  snoop-port address.
- snoopTagOut / snoopStateOut / snoopDataOut  in  TAG_WIDTH / STATE_TYPE / DATA_WIDTH  combinational snoop-port read.
- snoopStateIn  out  STATE_TYPE  next state from protocol.
- snoopWriteState  out  1  one-cycle state write strobe.
- protocolStateOut  out  STATE_TYPE  snoopStateOut on a hit, else INVALID_STATE.
- protocolStateIn  in  STATE_TYPE  next state for (commandIn, protocolStateOut).
- protocolWriteBackRequired  in  1  block must be flushed.
- masterAddress  out  A  {addressIn tag, addressIn index, wordCounter}.
- masterDataOut  out  DATA_WIDTH  = snoopDataOut.
- masterWriteEnabled  out  1  memory write request.
- masterFunctionComplete  in  1  memory write done.
- snoopAck  out  1  this snooper has finished the current command.
- snoopBusy  out  1  high in LOOKUP, FLUSH_*, UPDATE_STATE; the CPU controller stalls `accessEnable` on it.

## Operation
- hit = snoopTagOut == addressIn tag AND snoopStateOut != INVALID_STATE.
- snoopIndex is always the addressIn index. snoopOffset is wordCounter in the FLUSH states and the addressIn offset otherwise.
- IDLE: when commandIn ∉ {NONE, BUS_WRITEBACK} and ownRequest == 0, go to LOOKUP. When commandIn == BUS_WRITEBACK and ownRequest == 0, go straight to ACK_HOLD.
- LOOKUP: evaluates the registered decision.
  - Miss: go to ACK_HOLD.
  - Hit with protocolWriteBackRequired: clear wordCounter, go to FLUSH_REQUEST.
  - Hit with protocolStateIn != snoopStateOut: go to UPDATE_STATE.
  - Otherwise: go to ACK_HOLD.
  - The next state is latched into a register here and is what drives snoopStateIn.
- FLUSH_REQUEST: raise masterWriteEnabled, go to FLUSH_WAIT.
- FLUSH_WAIT: on masterFunctionComplete, drop masterWriteEnabled and increment wordCounter. If wordCounter was all ones, go to UPDATE_STATE; else go to FLUSH_REQUEST.
- UPDATE_STATE: assert snoopWriteState for one cycle, go to ACK_HOLD.
- ACK_HOLD: snoopAck = 1 until commandIn == NONE, then go to IDLE with snoopAck = 0.
- Coherence contract: for BUS_READ or BUS_READ_EXCLUSIVE on a dirty hit, all words reach memory before snoopAck rises.

## Timing
- Reset values: state IDLE, wordCounter 0, snoopAck 0, snoopWriteState 0, masterWriteEnabled 0, snoopBusy 0.
- Reset asserted mid-flush drops masterWriteEnabled on the next edge; no state write occurs.
- Clean miss: command seen in IDLE at cycle 0, LOOKUP at cycle 1, snoopAck at cycle 2.
- Hit needing only a state change: snoopWriteState at cycle 2, snoopAck at cycle 3.
- Flush: 2 cycles per word plus memory latency, then 1 cycle of UPDATE_STATE, then snoopAck.
- commandIn falling to NONE:
  - During LOOKUP: return to IDLE, no write.
  - During FLUSH_*: finish the word in flight, then go to IDLE with no state write; the block stays dirty.
  - During UPDATE_STATE: the write completes.
- ownRequest rising while not in IDLE: ignored.
- A new command only starts from IDLE, so back-to-back commands need one NONE cycle between them.
- wordCounter wraps to 0 after the last word.

## Structure
- commands package, shared with the CPU side: Command enum.
- SnoopState enum {IDLE, LOOKUP, FLUSH_REQUEST, FLUSH_WAIT, UPDATE_STATE, ACK_HOLD}, logic[2:0], placed in a new snoop_pkg.
- One natural sub-module: block_flush_sequencer (wordCounter plus FLUSH_REQUEST/FLUSH_WAIT handshake, with start/done ports), reusable by the CPU-side writeback.

## Test plan
1. BUS_READ to address 0x1A4, tag mismatch → snoopAck at cycle 2, no masterWriteEnabled, no snoopWriteState.
2. BUS_INVALIDATE, hit in shared state, protocolStateIn = INVALID → snoopWriteState pulse with snoopStateIn = INVALID_STATE at cycle 2, snoopAck at cycle 3.
3. BUS_READ_EXCLUSIVE, hit modified, OFFSET_WIDTH = 2, memory completes 3 cycles after each request → 4 writes to masterAddress …0,1,2,3 carrying snoopDataOut, then state write INVALID, then snoopAck.
4. BUS_READ, hit modified → flush of 4 words, state downgraded to shared, snoopAck held until commandIn = NONE, then 0 the next cycle.
5. ownRequest = 1 with BUS_INVALIDATE → stays in IDLE, snoopAck and snoopBusy remain 0.
6. Reset asserted after the second flush word → masterWriteEnabled 0 and state IDLE on the next edge; no state write.

Source files
------------

// File: rtl/commands_pkg.sv
// Bus command encodings shared by the CPU-side controller and the snoop responder.
package commands;

  typedef enum logic [2:0] {
    NONE               = 3'd0,
    BUS_READ           = 3'd1,
    BUS_READ_EXCLUSIVE = 3'd2,
    BUS_INVALIDATE     = 3'd3,
    BUS_WRITEBACK      = 3'd4
  } Command;

endpackage

// File: rtl/snoop_pkg.sv
// Snoop responder state encoding.
package snoop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FLUSH_REQUEST,
    FLUSH_WAIT,
    UPDATE_STATE,
    ACK_HOLD
  } SnoopState;

endpackage

// File: rtl/block_flush_sequencer.sv
// Word counter and memory write handshake for flushing one cache block.
// The owner pulses start to rewind the counter, then raises issue for one
// cycle per word; blockDone marks acceptance of the final word.
module block_flush_sequencer #(
  parameter int OFFSET_WIDTH = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    issue,
  input  logic                    masterFunctionComplete,
  output logic                    masterWriteEnabled,
  output logic [OFFSET_WIDTH-1:0] wordCounter,
  output logic                    wordDone,
  output logic                    blockDone
);

  assign wordDone  = masterWriteEnabled && masterFunctionComplete;
  assign blockDone = wordDone && (&wordCounter);

  // Hold the write request until memory accepts it, then step to the next word.
  always_ff @(posedge clock) begin
    if (reset) begin
      masterWriteEnabled <= 1'b0;
      wordCounter        <= '0;
    end else begin
      if (start) begin
        wordCounter <= '0;
      end else if (wordDone) begin
        wordCounter <= wordCounter + 1'b1;
      end

      if (issue) begin
        masterWriteEnabled <= 1'b1;
      end else if (wordDone) begin
        masterWriteEnabled <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/snoop_controller.sv
// Bus-side snoop responder for the invalidate-protocol cache: looks up the
// snooped block, flushes it if dirty, applies the protocol's next state and
// acknowledges the current bus command.
module snoop_controller
  import commands::*, snoop_pkg::*;
#(
  parameter int        OFFSET_WIDTH  = 2,
  parameter int        INDEX_WIDTH   = 4,
  parameter int        TAG_WIDTH     = 8,
  parameter int        DATA_WIDTH    = 32,
  parameter type       STATE_TYPE    = logic [1:0],
  parameter STATE_TYPE INVALID_STATE = '0
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  Command                                      commandIn,
  input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] addressIn,
  input  logic                                        ownRequest,
  output logic [INDEX_WIDTH-1:0]                      snoopIndex,
  output logic [OFFSET_WIDTH-1:0]                     snoopOffset,
  input  logic [TAG_WIDTH-1:0]                        snoopTagOut,
  input  STATE_TYPE                                   snoopStateOut,
  input  logic [DATA_WIDTH-1:0]                       snoopDataOut,
  output STATE_TYPE                                   snoopStateIn,
  output logic                                        snoopWriteState,
  output STATE_TYPE                                   protocolStateOut,
  input  STATE_TYPE                                   protocolStateIn,
  input  logic                                        protocolWriteBackRequired,
  output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] masterAddress,
  output logic [DATA_WIDTH-1:0]                       masterDataOut,
  output logic                                        masterWriteEnabled,
  input  logic                                        masterFunctionComplete,
  output logic                                        snoopAck,
  output logic                                        snoopBusy
);

  localparam int ADDRESS_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

  SnoopState                state;
  STATE_TYPE                nextStateReg;
  logic                     abortPending;
  logic [TAG_WIDTH-1:0]     addressTag;
  logic [INDEX_WIDTH-1:0]   addressIndex;
  logic [OFFSET_WIDTH-1:0]  addressOffset;
  logic                     hit;
  logic                     commandIdle;
  logic                     inFlush;
  logic                     flushStart;
  logic                     flushIssue;
  logic                     wordDone;
  logic                     blockDone;
  logic [OFFSET_WIDTH-1:0]  wordCounter;

  assign addressTag    = addressIn[ADDRESS_WIDTH-1 -: TAG_WIDTH];
  assign addressIndex  = addressIn[OFFSET_WIDTH +: INDEX_WIDTH];
  assign addressOffset = addressIn[OFFSET_WIDTH-1:0];

  assign commandIdle = (commandIn == NONE);
  assign hit         = (snoopTagOut == addressTag) && (snoopStateOut != INVALID_STATE);
  assign inFlush     = (state == FLUSH_REQUEST) || (state == FLUSH_WAIT);

  assign snoopIndex       = addressIndex;
  assign snoopOffset      = inFlush ? wordCounter : addressOffset;
  assign protocolStateOut = hit ? snoopStateOut : INVALID_STATE;
  assign snoopStateIn     = nextStateReg;
  assign masterAddress    = {addressTag, addressIndex, wordCounter};
  assign masterDataOut    = snoopDataOut;
  assign snoopBusy        = (state == LOOKUP) || inFlush || (state == UPDATE_STATE);

  assign flushStart = (state == LOOKUP) && !commandIdle && hit && protocolWriteBackRequired;
  assign flushIssue = (state == FLUSH_REQUEST) && !commandIdle;

  block_flush_sequencer #(
    .OFFSET_WIDTH(OFFSET_WIDTH)
  ) flush_sequencer (
    .clock                 (clock),
    .reset                 (reset),
    .start                 (flushStart),
    .issue                 (flushIssue),
    .masterFunctionComplete(masterFunctionComplete),
    .masterWriteEnabled    (masterWriteEnabled),
    .wordCounter           (wordCounter),
    .wordDone              (wordDone),
    .blockDone             (blockDone)
  );

  // Command sequencing: lookup, optional flush, state write, acknowledge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      nextStateReg    <= INVALID_STATE;
      abortPending    <= 1'b0;
      snoopAck        <= 1'b0;
      snoopWriteState <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          abortPending <= 1'b0;
          if (!ownRequest) begin
            if (commandIn == BUS_WRITEBACK) begin
              state    <= ACK_HOLD;
              snoopAck <= 1'b1;
            end else if (!commandIdle) begin
              state <= LOOKUP;
            end
          end
        end

        LOOKUP: begin
          nextStateReg <= protocolStateIn;
          if (commandIdle) begin
            state <= IDLE;
          end else if (!hit) begin
            state    <= ACK_HOLD;
            snoopAck <= 1'b1;
          end else if (protocolWriteBackRequired) begin
            state <= FLUSH_REQUEST;
          end else if (protocolStateIn != snoopStateOut) begin
            state           <= UPDATE_STATE;
            snoopWriteState <= 1'b1;
          end else begin
            state    <= ACK_HOLD;
            snoopAck <= 1'b1;
          end
        end

        FLUSH_REQUEST: begin
          state <= commandIdle ? IDLE : FLUSH_WAIT;
        end

        // A command withdrawn mid-word is remembered so the word in flight
        // still completes, after which the block is left dirty.
        FLUSH_WAIT: begin
          if (commandIdle) begin
            abortPending <= 1'b1;
          end
          if (wordDone) begin
            if (commandIdle || abortPending) begin
              state        <= IDLE;
              abortPending <= 1'b0;
            end else if (blockDone) begin
              state           <= UPDATE_STATE;
              snoopWriteState <= 1'b1;
            end else begin
              state <= FLUSH_REQUEST;
            end
          end
        end

        UPDATE_STATE: begin
          snoopWriteState <= 1'b0;
          snoopAck        <= 1'b1;
          state           <= ACK_HOLD;
        end

        ACK_HOLD: begin
          if (commandIdle) begin
            snoopAck <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_controller.sv
// Directed testbench for snoop_controller.
module tb_snoop_controller;
  import commands::*;

  localparam logic [1:0] ST_INVALID  = 2'd0;
  localparam logic [1:0] ST_SHARED   = 2'd1;
  localparam logic [1:0] ST_MODIFIED = 2'd2;

  logic        clock;
  logic        reset;
  Command      commandIn;
  logic [13:0] addressIn;
  logic        ownRequest;
  logic [3:0]  snoopIndex;
  logic [1:0]  snoopOffset;
  logic [7:0]  snoopTagOut;
  logic [1:0]  snoopStateOut;
  logic [31:0] snoopDataOut;
  logic [1:0]  snoopStateIn;
  logic        snoopWriteState;
  logic [1:0]  protocolStateOut;
  logic [1:0]  protocolStateIn;
  logic        protocolWriteBackRequired;
  logic [13:0] masterAddress;
  logic [31:0] masterDataOut;
  logic        masterWriteEnabled;
  logic        masterFunctionComplete = 1'b0;
  logic        snoopAck;
  logic        snoopBusy;

  // cache snoop-port model
  logic [7:0]  tagMem   [16];
  logic [1:0]  stateMem [16];
  logic [31:0] dataMem  [16][4];

  // observation logs
  logic [13:0] logAddr [64];
  logic [31:0] logData [64];
  int          logCount   = 0;
  int          memLatency = 0;
  int          writeCount = 0;
  logic [1:0]  lastWritten = 2'd3;

  int checks   = 0;
  int failures = 0;

  assign snoopTagOut   = tagMem[snoopIndex];
  assign snoopStateOut = stateMem[snoopIndex];
  assign snoopDataOut  = dataMem[snoopIndex][snoopOffset];

  snoop_controller #(
    .OFFSET_WIDTH (2),
    .INDEX_WIDTH  (4),
    .TAG_WIDTH    (8),
    .DATA_WIDTH   (32),
    .INVALID_STATE(2'd0)
  ) dut (
    .clock                    (clock),
    .reset                    (reset),
    .commandIn                (commandIn),
    .addressIn                (addressIn),
    .ownRequest               (ownRequest),
    .snoopIndex               (snoopIndex),
    .snoopOffset              (snoopOffset),
    .snoopTagOut              (snoopTagOut),
    .snoopStateOut            (snoopStateOut),
    .snoopDataOut             (snoopDataOut),
    .snoopStateIn             (snoopStateIn),
    .snoopWriteState          (snoopWriteState),
    .protocolStateOut         (protocolStateOut),
    .protocolStateIn          (protocolStateIn),
    .protocolWriteBackRequired(protocolWriteBackRequired),
    .masterAddress            (masterAddress),
    .masterDataOut            (masterDataOut),
    .masterWriteEnabled       (masterWriteEnabled),
    .masterFunctionComplete   (masterFunctionComplete),
    .snoopAck                 (snoopAck),
    .snoopBusy                (snoopBusy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory: completes on the third posedge after the request rises
  always @(negedge clock) begin
    if (masterFunctionComplete) begin
      masterFunctionComplete = 1'b0;
    end else if (masterWriteEnabled) begin
      if (memLatency == 2) begin
        masterFunctionComplete = 1'b1;
        memLatency = 0;
        if (logCount < 64) begin
          logAddr[logCount] = masterAddress;
          logData[logCount] = masterDataOut;
        end
        logCount++;
      end else begin
        memLatency++;
      end
    end else begin
      memLatency = 0;
    end
  end

  // state write monitor
  always @(negedge clock) begin
    if (snoopWriteState) begin
      writeCount++;
      lastWritten = snoopStateIn;
    end
  end

  task automatic test_reset();
    reset = 1'b1; commandIn = NONE; ownRequest = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (snoopAck !== 1'b0) begin failures++; $display("FAIL reset_ack got %b expected 0", snoopAck); end
    checks++; if (snoopWriteState !== 1'b0) begin failures++; $display("FAIL reset_sws got %b expected 0", snoopWriteState); end
    checks++; if (masterWriteEnabled !== 1'b0) begin failures++; $display("FAIL reset_mwe got %b expected 0", masterWriteEnabled); end
    checks++; if (snoopBusy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", snoopBusy); end
    checks++; if (masterAddress[1:0] !== 2'b00) begin failures++; $display("FAIL reset_wordcounter got %0d expected 0", masterAddress[1:0]); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_clean_miss();
    int w0, l0;
    tagMem[9] = 8'h07; stateMem[9] = ST_SHARED;
    addressIn = 14'h1A4; protocolStateIn = ST_SHARED; protocolWriteBackRequired = 1'b0;
    w0 = writeCount; l0 = logCount;
    commandIn = BUS_READ; #1;
    checks++; if (snoopIndex !== 4'd9) begin failures++; $display("FAIL miss_index got %0d expected 9", snoopIndex); end
    @(negedge clock);
    checks++; if (snoopBusy !== 1'b1) begin failures++; $display("FAIL miss_busy_c1 got %b expected 1", snoopBusy); end
    checks++; if (protocolStateOut !== ST_INVALID) begin failures++; $display("FAIL miss_protocol_state got %0d expected 0", protocolStateOut); end
    checks++; if (snoopAck !== 1'b0) begin failures++; $display("FAIL miss_ack_c1 got %b expected 0", snoopAck); end
    @(negedge clock);
    checks++; if (snoopAck !== 1'b1) begin failures++; $display("FAIL miss_ack_c2 got %b expected 1", snoopAck); end
    commandIn = NONE;
    @(negedge clock);
    checks++; if (snoopAck !== 1'b0) begin failures++; $display("FAIL miss_ack_release got %b expected 0", snoopAck); end
    checks++; if (writeCount != w0 || logCount != l0) begin failures++; $display("FAIL miss_side_effects writes %0d words %0d expected 0 0", writeCount - w0, logCount - l0); end
  endtask

  task automatic test_invalidate_hit();
    int w0;
    tagMem[9] = 8'h06; stateMem[9] = ST_SHARED;
    addressIn = 14'h1A4; protocolStateIn = ST_INVALID; protocolWriteBackRequired = 1'b0;
    w0 = writeCount;
    commandIn = BUS_INVALIDATE;
    @(negedge clock);
    checks++; if (protocolStateOut !== ST_SHARED) begin failures++; $display("FAIL inv_protocol_state got %0d expected 1", protocolStateOut); end
    @(negedge clock);
    checks++; if (snoopWriteState !== 1'b1) begin failures++; $display("FAIL inv_sws_c2 got %b expected 1", snoopWriteState); end
    checks++; if (snoopStateIn !== ST_INVALID) begin failures++; $display("FAIL inv_state_in got %0d expected 0", snoopStateIn); end
    checks++; if (snoopAck !== 1'b0) begin failures++; $display("FAIL inv_ack_c2 got %b expected 0", snoopAck); end
    @(negedge clock);
    checks++; if (snoopWriteState !== 1'b0) begin failures++; $display("FAIL inv_sws_c3 got %b expected 0", snoopWriteState); end
    checks++; if (snoopAck !== 1'b1) begin failures++; $display("FAIL inv_ack_c3 got %b expected 1", snoopAck); end
    checks++; if (writeCount != w0 + 1) begin failures++; $display("FAIL inv_write_count got %0d expected 1", writeCount - w0); end
    commandIn = NONE;
    @(negedge clock);
  endtask

  task automatic test_dirty_flush(input Command cmd, input logic [1:0] nextState);
    int w0, l0, cyc;
    logic [13:0] expAddr;
    logic [31:0] expData;
    tagMem[14] = 8'h0A; stateMem[14] = ST_MODIFIED;
    addressIn = 14'h2BA; protocolStateIn = nextState; protocolWriteBackRequired = 1'b1;
    w0 = writeCount; l0 = logCount; cyc = 0;
    commandIn = cmd;
    while (snoopAck !== 1'b1 && cyc < 60) begin
      @(negedge clock);
      cyc++;
    end
    checks++; if (cyc != 19) begin failures++; $display("FAIL flush_ack_cycle got %0d expected 19", cyc); end
    checks++; if (logCount - l0 != 4) begin failures++; $display("FAIL flush_word_count got %0d expected 4", logCount - l0); end
    for (int i = 0; i < 4; i++) begin
      expAddr = 14'h2B8 + 14'(i);
      expData = 32'hD000_0000 + 32'(i);
      checks++; if (logAddr[l0 + i] !== expAddr) begin failures++; $display("FAIL flush_addr%0d got %h expected %h", i, logAddr[l0 + i], expAddr); end
      checks++; if (logData[l0 + i] !== expData) begin failures++; $display("FAIL flush_data%0d got %h expected %h", i, logData[l0 + i], expData); end
    end
    checks++; if (writeCount != w0 + 1) begin failures++; $display("FAIL flush_write_count got %0d expected 1", writeCount - w0); end
    checks++; if (lastWritten !== nextState) begin failures++; $display("FAIL flush_written_state got %0d expected %0d", lastWritten, nextState); end
    checks++; if (masterAddress[1:0] !== 2'b00) begin failures++; $display("FAIL flush_counter_wrap got %0d expected 0", masterAddress[1:0]); end
    repeat (3) begin
      @(negedge clock);
      checks++; if (snoopAck !== 1'b1) begin failures++; $display("FAIL flush_ack_hold got %b expected 1", snoopAck); end
    end
    commandIn = NONE;
    @(negedge clock);
    checks++; if (snoopAck !== 1'b0) begin failures++; $display("FAIL flush_ack_release got %b expected 0", snoopAck); end
    checks++; if (snoopBusy !== 1'b0) begin failures++; $display("FAIL flush_busy_release got %b expected 0", snoopBusy); end
  endtask

  task automatic test_own_request();
    int w0;
    tagMem[9] = 8'h06; stateMem[9] = ST_SHARED;
    addressIn = 14'h1A4; protocolStateIn = ST_INVALID; protocolWriteBackRequired = 1'b0;
    w0 = writeCount;
    ownRequest = 1'b1; commandIn = BUS_INVALIDATE;
    repeat (4) begin
      @(negedge clock);
      checks++; if (snoopBusy !== 1'b0 || snoopAck !== 1'b0) begin failures++; $display("FAIL own_idle busy %b ack %b expected 0 0", snoopBusy, snoopAck); end
    end
    checks++; if (writeCount != w0) begin failures++; $display("FAIL own_write_count got %0d expected 0", writeCount - w0); end
    commandIn = NONE; ownRequest = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_lookup_abort();
    int w0;
    tagMem[9] = 8'h06; stateMem[9] = ST_SHARED;
    addressIn = 14'h1A4; protocolStateIn = ST_INVALID; protocolWriteBackRequired = 1'b0;
    w0 = writeCount;
    commandIn = BUS_INVALIDATE;
    @(negedge clock);
    commandIn = NONE;
    @(negedge clock);
    checks++; if (snoopBusy !== 1'b0 || snoopAck !== 1'b0 || snoopWriteState !== 1'b0) begin failures++; $display("FAIL lookup_abort busy %b ack %b sws %b expected 0 0 0", snoopBusy, snoopAck, snoopWriteState); end
    @(negedge clock);
    checks++; if (writeCount != w0) begin failures++; $display("FAIL lookup_abort_writes got %0d expected 0", writeCount - w0); end
  endtask

  task automatic test_flush_abort();
    int w0, l0;
    tagMem[14] = 8'h0A; stateMem[14] = ST_MODIFIED;
    addressIn = 14'h2BA; protocolStateIn = ST_INVALID; protocolWriteBackRequired = 1'b1;
    w0 = writeCount; l0 = logCount;
    commandIn = BUS_READ_EXCLUSIVE;
    repeat (3) @(negedge clock);
    checks++; if (masterWriteEnabled !== 1'b1) begin failures++; $display("FAIL fabort_mwe_c3 got %b expected 1", masterWriteEnabled); end
    commandIn = NONE;
    repeat (3) @(negedge clock);
    checks++; if (snoopBusy !== 1'b0 || masterWriteEnabled !== 1'b0 || snoopAck !== 1'b0) begin failures++; $display("FAIL fabort_idle busy %b mwe %b ack %b expected 0 0 0", snoopBusy, masterWriteEnabled, snoopAck); end
    checks++; if (logCount - l0 != 1) begin failures++; $display("FAIL fabort_words got %0d expected 1", logCount - l0); end
    checks++; if (writeCount != w0) begin failures++; $display("FAIL fabort_writes got %0d expected 0", writeCount - w0); end
  endtask

  task automatic test_writeback();
    commandIn = BUS_WRITEBACK;
    @(negedge clock);
    checks++; if (snoopAck !== 1'b1 || snoopBusy !== 1'b0) begin failures++; $display("FAIL wb_ack ack %b busy %b expected 1 0", snoopAck, snoopBusy); end
    commandIn = NONE;
    @(negedge clock);
    checks++; if (snoopAck !== 1'b0) begin failures++; $display("FAIL wb_release got %b expected 0", snoopAck); end
  endtask

  task automatic test_reset_mid_flush();
    int w0, l0, cyc;
    tagMem[14] = 8'h0A; stateMem[14] = ST_MODIFIED;
    addressIn = 14'h2BA; protocolStateIn = ST_INVALID; protocolWriteBackRequired = 1'b1;
    w0 = writeCount; l0 = logCount; cyc = 0;
    commandIn = BUS_READ_EXCLUSIVE;
    while (!(masterWriteEnabled === 1'b1 && masterAddress[1:0] === 2'd2) && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    checks++; if (cyc != 11) begin failures++; $display("FAIL rflush_third_word_cycle got %0d expected 11", cyc); end
    checks++; if (logCount - l0 != 2) begin failures++; $display("FAIL rflush_words_before got %0d expected 2", logCount - l0); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (masterWriteEnabled !== 1'b0) begin failures++; $display("FAIL rflush_mwe got %b expected 0", masterWriteEnabled); end
    checks++; if (snoopBusy !== 1'b0 || snoopAck !== 1'b0) begin failures++; $display("FAIL rflush_idle busy %b ack %b expected 0 0", snoopBusy, snoopAck); end
    commandIn = NONE;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (writeCount != w0) begin failures++; $display("FAIL rflush_writes got %0d expected 0", writeCount - w0); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tagMem[i] = 8'hFF;
      stateMem[i] = ST_INVALID;
      for (int w = 0; w < 4; w++) begin
        dataMem[i][w] = 32'h0;
      end
    end
    for (int w = 0; w < 4; w++) begin
      dataMem[14][w] = 32'hD000_0000 + 32'(w);
    end
    reset = 1'b1; commandIn = NONE; ownRequest = 1'b0; addressIn = '0;
    protocolStateIn = ST_INVALID; protocolWriteBackRequired = 1'b0;

    test_reset();
    test_clean_miss();
    test_invalidate_hit();
    test_dirty_flush(BUS_READ_EXCLUSIVE, ST_INVALID);
    test_dirty_flush(BUS_READ, ST_SHARED);
    test_own_request();
    test_lookup_abort();
    test_flush_abort();
    test_writeback();
    test_reset_mid_flush();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
